// File: rtl/fetch_decode.sv
// Single-outstanding Wishbone fetch engine with a one-cycle field decoder.
// Reads land in o_instruction and are split into fields the cycle after o_fetch_done.
module fetch_decode (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_enable,
  input  logic [31:0] i_pc,
  input  logic        i_we,
  input  logic [31:0] i_wdata,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  input  logic        i_wb_ack,
  input  logic [31:0] i_wb_data,
  output logic [31:0] o_instruction,
  output logic        o_fetch_done,
  output logic [3:0]  o_opcode,
  output logic [3:0]  o_extra,
  output logic [3:0]  o_operandA,
  output logic [3:0]  o_operandB,
  output logic [15:0] o_immediate,
  output logic        o_decode_done
);

  typedef enum logic [1:0] {StIdle, StBus, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, data_q, instr_q;
  logic        we_q;
  logic [3:0]  opcode_q, extra_q, operand_a_q, operand_b_q;
  logic [15:0] imm_q;
  logic        decode_done_q;

  logic        start, read_ack, decode;

  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    read_ack = 1'b0;
    decode   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_enable) begin
          start   = 1'b1;
          state_d = StBus;
        end
      end
      StBus: begin
        if (i_wb_ack) begin
          read_ack = ~we_q;
          state_d  = StDone;
        end
      end
      StDone: begin
        decode  = ~we_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      data_q        <= '0;
      we_q          <= 1'b0;
      instr_q       <= '0;
      opcode_q      <= '0;
      extra_q       <= '0;
      operand_a_q   <= '0;
      operand_b_q   <= '0;
      imm_q         <= '0;
      decode_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      decode_done_q <= decode;
      if (start) begin
        addr_q <= i_pc;
        data_q <= i_wdata;
        we_q   <= i_we;
      end
      if (read_ack) begin
        instr_q <= i_wb_data;
      end
      if (decode) begin
        opcode_q    <= instr_q[31:28];
        extra_q     <= instr_q[27:24];
        operand_a_q <= instr_q[23:20];
        operand_b_q <= instr_q[19:16];
        imm_q       <= instr_q[15:0];
      end
    end
  end

  // Address/data persist while idle; only cyc/stb (and we) are qualified by state.
  assign o_wb_cyc      = (state_q == StBus);
  assign o_wb_stb      = (state_q == StBus);
  assign o_wb_we       = (state_q == StBus) & we_q;
  assign o_wb_addr     = addr_q;
  assign o_wb_data     = data_q;
  assign o_instruction = instr_q;
  assign o_fetch_done  = (state_q == StDone);
  assign o_opcode      = opcode_q;
  assign o_extra       = extra_q;
  assign o_operandA    = operand_a_q;
  assign o_operandB    = operand_b_q;
  assign o_immediate   = imm_q;
  assign o_decode_done = decode_done_q;

endmodule

// File: tb/tb_fetch_decode.sv
// Directed table plus randomized transactions for fetch_decode, checked against a
// transaction-level model of the fetch/decode behaviour.
module tb_fetch_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_enable;
  logic [31:0] i_pc;
  logic        i_we;
  logic [31:0] i_wdata;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [31:0] o_wb_addr, o_wb_data;
  logic        i_wb_ack;
  logic [31:0] i_wb_data;
  logic [31:0] o_instruction;
  logic        o_fetch_done;
  logic [3:0]  o_opcode, o_extra, o_operandA, o_operandB;
  logic [15:0] o_immediate;
  logic        o_decode_done;

  fetch_decode dut (
    .clk          (clk),
    .reset        (reset),
    .i_enable     (i_enable),
    .i_pc         (i_pc),
    .i_we         (i_we),
    .i_wdata      (i_wdata),
    .o_wb_cyc     (o_wb_cyc),
    .o_wb_stb     (o_wb_stb),
    .o_wb_we      (o_wb_we),
    .o_wb_addr    (o_wb_addr),
    .o_wb_data    (o_wb_data),
    .i_wb_ack     (i_wb_ack),
    .i_wb_data    (i_wb_data),
    .o_instruction(o_instruction),
    .o_fetch_done (o_fetch_done),
    .o_opcode     (o_opcode),
    .o_extra      (o_extra),
    .o_operandA   (o_operandA),
    .o_operandB   (o_operandB),
    .o_immediate  (o_immediate),
    .o_decode_done(o_decode_done)
  );

  always #5 clk = ~clk;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  typedef struct {
    logic [31:0] pc;
    logic        we;
    logic [31:0] wdata;
    int unsigned delay;
    logic [31:0] rdata;
    logic        stray;
    logic [31:0] exp_instr;
    logic [3:0]  exp_op, exp_ex, exp_a, exp_b;
    logic [15:0] exp_imm;
  } vec_t;

  // Transaction-level model state: last read word and its decoded fields.
  logic [31:0] mdl_instr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_fields(input string tag, input logic [3:0] op, input logic [3:0] ex,
                            input logic [3:0] a, input logic [3:0] b, input logic [15:0] imm);
    chk({tag, " opcode"}, {28'd0, o_opcode}, {28'd0, op});
    chk({tag, " extra"}, {28'd0, o_extra}, {28'd0, ex});
    chk({tag, " operandA"}, {28'd0, o_operandA}, {28'd0, a});
    chk({tag, " operandB"}, {28'd0, o_operandB}, {28'd0, b});
    chk({tag, " immediate"}, {16'd0, o_immediate}, {16'd0, imm});
  endtask

  // Issue one transaction at the current negedge and check it cycle by cycle.
  task automatic txn(input vec_t v);
    i_enable = 1'b1;
    i_pc     = v.pc;
    i_we     = v.we;
    i_wdata  = v.wdata;
    tick();
    for (int k = 0; k <= int'(v.delay); k++) begin
      chk("bus cyc", {31'd0, o_wb_cyc}, 32'd1);
      chk("bus stb", {31'd0, o_wb_stb}, 32'd1);
      chk("bus addr", o_wb_addr, v.pc);
      chk("bus we", {31'd0, o_wb_we}, {31'd0, v.we});
      if (v.we) chk("bus wdata", o_wb_data, v.wdata);
      chk("no early done", {31'd0, o_fetch_done}, 32'd0);
      i_enable  = v.stray && (k == 0);
      i_pc      = 32'h0000_0010;
      i_wb_ack  = (k == int'(v.delay));
      i_wb_data = (k == int'(v.delay)) ? v.rdata : 32'hx;
      tick();
    end
    i_enable = 1'b0;
    i_wb_ack = 1'b0;
    chk("done cyc low", {31'd0, o_wb_cyc}, 32'd0);
    chk("done we low", {31'd0, o_wb_we}, 32'd0);
    chk("fetch_done", {31'd0, o_fetch_done}, 32'd1);
    chk("instruction", o_instruction, v.exp_instr);
    chk("decode not yet", {31'd0, o_decode_done}, 32'd0);
    tick();
    chk("fetch_done one cycle", {31'd0, o_fetch_done}, 32'd0);
    chk("decode_done", {31'd0, o_decode_done}, {31'd0, ~v.we});
    chk_fields("fields", v.exp_op, v.exp_ex, v.exp_a, v.exp_b, v.exp_imm);
    chk("addr held idle", o_wb_addr, v.pc);
    tick();
    chk("decode_done one cycle", {31'd0, o_decode_done}, 32'd0);
    chk("idle cyc", {31'd0, o_wb_cyc}, 32'd0);
  endtask

  vec_t tbl[4];
  vec_t rv;

  initial begin
    tbl[0] = '{32'hb000_0000, 1'b0, 32'h0, 0, 32'h1283_abcd, 1'b0,
               32'h1283_abcd, 4'h1, 4'h2, 4'h8, 4'h3, 16'habcd};
    tbl[1] = '{32'h0000_0100, 1'b0, 32'h0, 3, 32'h5a5a_1234, 1'b0,
               32'h5a5a_1234, 4'h5, 4'ha, 4'h5, 4'ha, 16'h1234};
    tbl[2] = '{32'hb000_fff8, 1'b1, 32'hdead_beef, 1, 32'h0bad_f00d, 1'b0,
               32'h5a5a_1234, 4'h5, 4'ha, 4'h5, 4'ha, 16'h1234};
    tbl[3] = '{32'h0000_0040, 1'b0, 32'h0, 2, 32'hf00d_cafe, 1'b1,
               32'hf00d_cafe, 4'hf, 4'h0, 4'h0, 4'hd, 16'hcafe};

    reset = 1'b0; i_enable = 1'b0; i_pc = 32'hffff_ffff; i_we = 1'b1;
    i_wdata = 32'hffff_ffff; i_wb_ack = 1'b1; i_wb_data = 32'hffff_ffff;
    tick();
    tick();
    chk("reset cyc", {31'd0, o_wb_cyc}, 32'd0);
    chk("reset stb", {31'd0, o_wb_stb}, 32'd0);
    chk("reset we", {31'd0, o_wb_we}, 32'd0);
    chk("reset addr", o_wb_addr, 32'd0);
    chk("reset data", o_wb_data, 32'd0);
    chk("reset instr", o_instruction, 32'd0);
    chk("reset fetch_done", {31'd0, o_fetch_done}, 32'd0);
    chk("reset decode_done", {31'd0, o_decode_done}, 32'd0);
    chk_fields("reset", 4'h0, 4'h0, 4'h0, 4'h0, 16'h0);
    reset = 1'b1; i_wb_ack = 1'b0; i_we = 1'b0;

    for (int i = 0; i < 4; i++) txn(tbl[i]);

    // Stray ack while idle must not start or finish anything.
    i_wb_ack = 1'b1; i_wb_data = 32'h7777_7777;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stray ack cyc", {31'd0, o_wb_cyc}, 32'd0);
      chk("stray ack fetch_done", {31'd0, o_fetch_done}, 32'd0);
      chk("stray ack decode_done", {31'd0, o_decode_done}, 32'd0);
      chk("stray ack instr", o_instruction, 32'hf00d_cafe);
    end
    i_wb_ack = 1'b0;

    // Reset in BUS aborts; a later ack is ignored.
    i_enable = 1'b1; i_pc = 32'h0000_2000; i_we = 1'b0;
    tick();
    i_enable = 1'b0;
    chk("abort cyc before", {31'd0, o_wb_cyc}, 32'd1);
    reset = 1'b0; i_wb_ack = 1'b1; i_wb_data = 32'h1111_1111;
    tick();
    reset = 1'b1;
    chk("abort cyc", {31'd0, o_wb_cyc}, 32'd0);
    chk("abort stb", {31'd0, o_wb_stb}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort cyc after", {31'd0, o_wb_cyc}, 32'd0);
      chk("abort fetch_done", {31'd0, o_fetch_done}, 32'd0);
      chk("abort decode_done", {31'd0, o_decode_done}, 32'd0);
      chk("abort instr", o_instruction, 32'd0);
      chk("abort addr", o_wb_addr, 32'd0);
    end
    chk_fields("abort", 4'h0, 4'h0, 4'h0, 4'h0, 16'h0);
    i_wb_ack = 1'b0;

    // Randomized transactions; model holds the last read word and derives fields arithmetically.
    mdl_instr = 32'd0;
    for (int n = 0; n < 24; n++) begin
      rv.pc    = $urandom;
      rv.we    = ($urandom_range(0, 2) == 0);
      rv.wdata = $urandom;
      rv.delay = $urandom_range(0, 4);
      rv.rdata = $urandom;
      rv.stray = ($urandom_range(0, 3) == 0);
      if (!rv.we) mdl_instr = rv.rdata;
      rv.exp_instr = mdl_instr;
      rv.exp_op    = 4'((mdl_instr / 32'h1000_0000) % 16);
      rv.exp_ex    = 4'((mdl_instr / 32'h0100_0000) % 16);
      rv.exp_a     = 4'((mdl_instr / 32'h0010_0000) % 16);
      rv.exp_b     = 4'((mdl_instr / 32'h0001_0000) % 16);
      rv.exp_imm   = 16'(mdl_instr % 32'h0001_0000);
      txn(rv);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_decode.md
FETCH_DECODE -- requirements
Module: fetch_decode

Interface
REQ-001 Parameters: none; all widths fixed (32-bit address/data, 4-bit fields, 16-bit immediate).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 i_enable  input  1  one-cycle pulse starting a bus transaction.
REQ-005 i_pc  input  32  transaction address, sampled with i_enable.
REQ-006 i_we  input  1  1 = write, 0 = read/fetch, sampled with i_enable.
REQ-007 i_wdata  input  32  write data, sampled with i_enable.
REQ-008 o_wb_cyc, o_wb_stb  output  1 each  Wishbone cycle and strobe.
REQ-009 o_wb_we  output  1  Wishbone write enable.
REQ-010 o_wb_addr  output  32  Wishbone address.
REQ-011 o_wb_data  output  32  Wishbone write data.
REQ-012 i_wb_ack  input  1  Wishbone acknowledge.
REQ-013 i_wb_data  input  32  Wishbone read data.
REQ-014 o_instruction  output  32  last word read.
REQ-015 o_fetch_done  output  1  one-cycle pulse when a transaction ends.
REQ-016 o_opcode, o_extra, o_operandA, o_operandB  output  4 each  decoded fields.
REQ-017 o_immediate  output  16  decoded immediate.
REQ-018 o_decode_done  output  1  one-cycle pulse when decoded fields are valid.

Function
REQ-019 Fetch FSM states: IDLE, BUS, DONE.
REQ-020 IDLE + i_enable=1: latch i_pc, i_we, i_wdata; next cycle enter BUS with o_wb_cyc=o_wb_stb=1, o_wb_addr=latched pc, o_wb_we=latched we, o_wb_data=latched wdata.
REQ-021 BUS: cyc, stb, addr, we, data held constant until i_wb_ack=1; wait unbounded.
REQ-022 BUS + i_wb_ack=1: next cycle cyc=stb=we=0, state DONE, o_fetch_done=1 for exactly one cycle, then IDLE.
REQ-023 On an acked read, o_instruction <= i_wb_data in the ack edge; on a write, o_instruction is unchanged.
REQ-024 Minimum latency: i_enable at edge N, cyc at N+1, ack sampled at N+1 gives o_fetch_done high during N+2.
REQ-025 i_enable while in BUS or DONE is ignored (not queued).
REQ-026 i_wb_ack while in IDLE or DONE is ignored.
REQ-027 o_wb_addr and o_wb_data keep last values when idle; only cyc/stb qualify the bus.
REQ-028 Decode triggered only by completion of a read: cycle after o_fetch_done, outputs o_opcode=instr[31:28], o_extra=[27:24], o_operandA=[23:20], o_operandB=[19:16], o_immediate=[15:0], o_decode_done=1 one cycle.
REQ-029 Decoded fields hold until the next decode; write transactions never pulse o_decode_done.
REQ-030 Decode is purely field extraction; all 16 opcode values pass through unchecked.

Reset
REQ-031 reset=0 at a clock edge: FSM to IDLE; o_wb_cyc, o_wb_stb, o_wb_we, o_fetch_done, o_decode_done = 0; o_wb_addr, o_wb_data, o_instruction, all decoded fields = 0.
REQ-032 Reset during BUS aborts the transaction (cyc/stb drop next edge); a later ack is ignored, no done pulses.
REQ-033 Reset has priority over i_enable and i_wb_ack at the same edge.

Verification
REQ-034 Read, immediate ack: i_pc=0xb0000000, i_we=0, ack with data 0x1283abcd on first BUS cycle -> cyc 1 cycle, o_instruction=0x1283abcd, o_fetch_done at N+2, o_decode_done at N+3 with opcode=1, extra=2, A=8, B=3, imm=0xabcd.
REQ-035 Read, ack delayed 3 cycles -> cyc/stb/addr stable 4 cycles, single o_fetch_done pulse after ack.
REQ-036 Write: i_pc=0xb000fff8, i_we=1, i_wdata=0xdeadbeef -> o_wb_we=1, o_wb_data=0xdeadbeef during BUS; o_instruction unchanged; no o_decode_done.
REQ-037 i_enable pulsed again during BUS with i_pc=0x10 -> ignored; o_wb_addr stays at first address.
REQ-038 reset=0 while in BUS -> cyc/stb low next cycle, subsequent ack produces no done pulses, outputs zero.
REQ-039 Stray i_wb_ack in IDLE -> no state change, no pulses.
